// File: rtl/range_clip_cell_if.sv
// range_clip_cell_if: one link of the range-clip chain (range handshake, config-done level, sum token).
interface range_clip_cell_if #(
    parameter int RANGE_WIDTH = 49,
    parameter int SUM_WIDTH   = 56
);
    logic                   valid;
    logic                   ready;
    logic [RANGE_WIDTH-1:0] lo;
    logic [RANGE_WIDTH-1:0] hi;
    logic                   conf_done;
    logic                   sum_valid;
    logic [SUM_WIDTH-1:0]   sum;
    modport master (output valid, lo, hi, conf_done, sum_valid, sum, input ready);
    modport slave  (input valid, lo, hi, conf_done, sum_valid, sum, output ready);
endinterface

// File: rtl/range_clip_cell.sv
// range_clip_cell: one systolic stage that keeps a range, clips passing ranges against it and adds its size to the sum token.
// Optional RANGE_CLIP_CELL_DEBUG_EN adds dbg_drop_cnt_o, a saturating count of dropped inputs.
module range_clip_cell #(
    parameter int RANGE_WIDTH = 49,
    parameter int SUM_WIDTH   = 56
) (
    input logic clk,
    input logic rst_n,
    range_clip_cell_if.slave  up_i,
    range_clip_cell_if.master down_o
`ifdef RANGE_CLIP_CELL_DEBUG_EN
    ,
    output logic [15:0] dbg_drop_cnt_o
`endif
);
    localparam int RW = RANGE_WIDTH;
    localparam int SW = SUM_WIDTH;
    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;
    state_t state_q, state_d;
    logic occ_q, occ_d, dv_q, dv_d, dcd_q, dcd_d, dsv_q, dsv_d;
    logic [RW-1:0] st_lo_q, st_lo_d, st_hi_q, st_hi_d;
    logic [RW-1:0] pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
    logic [RW-1:0] dlo_q, dlo_d, dhi_q, dhi_d;
    logic [SW-1:0] dsum_q, dsum_d, size;
    logic free, acc, bad, dis, left, right, drop;
    assign free  = !dv_q || down_o.ready;
    assign acc   = up_i.valid && up_i.ready;
    assign bad   = up_i.lo > up_i.hi;
    assign dis   = up_i.hi < st_lo_q || up_i.lo > st_hi_q;
    assign left  = up_i.lo < st_lo_q;
    assign right = up_i.hi > st_hi_q;
    // Size is widened before the +1 so a full-width range cannot wrap.
    assign size  = occ_q ? {{(SW-RW){1'b0}}, st_hi_q - st_lo_q} + SW'(1) : '0;
    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        st_lo_d   = st_lo_q;
        st_hi_d   = st_hi_q;
        pend_lo_d = pend_lo_q;
        pend_hi_d = pend_hi_q;
        dv_d      = dv_q && !down_o.ready;
        dlo_d     = dlo_q;
        dhi_d     = dhi_q;
        dcd_d     = dcd_q;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (bad) begin
                        drop = 1'b1;
                    end else if (!occ_q) begin
                        occ_d   = 1'b1;
                        st_lo_d = up_i.lo;
                        st_hi_d = up_i.hi;
                    end else if (dis) begin
                        dv_d  = 1'b1;
                        dlo_d = up_i.lo;
                        dhi_d = up_i.hi;
                    end else if (left) begin
                        dv_d  = 1'b1;
                        dlo_d = up_i.lo;
                        dhi_d = st_lo_q - RW'(1);
                        if (right) begin
                            pend_lo_d = st_hi_q + RW'(1);
                            pend_hi_d = up_i.hi;
                            state_d   = SPLIT;
                        end
                    end else if (right) begin
                        dv_d  = 1'b1;
                        dlo_d = st_hi_q + RW'(1);
                        dhi_d = up_i.hi;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (up_i.conf_done && !dv_q) begin
                    state_d = DONE;
                    dcd_d   = 1'b1;
                end
            end
            SPLIT: begin
                if (free) begin
                    dv_d    = 1'b1;
                    dlo_d   = pend_lo_q;
                    dhi_d   = pend_hi_q;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end
    assign dsv_d  = state_q == DONE && up_i.sum_valid;
    assign dsum_d = dsv_d ? up_i.sum + size : dsum_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            occ_q     <= 1'b0;
            st_lo_q   <= '0;
            st_hi_q   <= '0;
            pend_lo_q <= '0;
            pend_hi_q <= '0;
            dv_q      <= 1'b0;
            dlo_q     <= '0;
            dhi_q     <= '0;
            dcd_q     <= 1'b0;
            dsv_q     <= 1'b0;
            dsum_q    <= '0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            st_lo_q   <= st_lo_d;
            st_hi_q   <= st_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_hi_q <= pend_hi_d;
            dv_q      <= dv_d;
            dlo_q     <= dlo_d;
            dhi_q     <= dhi_d;
            dcd_q     <= dcd_d;
            dsv_q     <= dsv_d;
            dsum_q    <= dsum_d;
        end
    end
    assign up_i.ready       = rst_n && state_q == IDLE && free && !up_i.conf_done;
    assign down_o.valid     = dv_q;
    assign down_o.lo        = dlo_q;
    assign down_o.hi        = dhi_q;
    assign down_o.conf_done = dcd_q;
    assign down_o.sum_valid = dsv_q;
    assign down_o.sum       = dsum_q;
`ifdef RANGE_CLIP_CELL_DEBUG_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign dbg_drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_range_clip_cell.sv
// tb_range_clip_cell: directed bench for range_clip_cell with a scoreboard of expected pieces and sums.
module tb_range_clip_cell;
    localparam int RW = 49;
    localparam int SW = 56;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    range_clip_cell_if #(.RANGE_WIDTH(RW), .SUM_WIDTH(SW)) up_if ();
    range_clip_cell_if #(.RANGE_WIDTH(RW), .SUM_WIDTH(SW)) dn_if ();
`ifdef RANGE_CLIP_CELL_DEBUG_EN
    logic [15:0] dbg;
    range_clip_cell #(.RANGE_WIDTH(RW), .SUM_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .up_i(up_if), .down_o(dn_if), .dbg_drop_cnt_o(dbg));
`else
    range_clip_cell #(.RANGE_WIDTH(RW), .SUM_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .up_i(up_if), .down_o(dn_if));
`endif
    int checks = 0;
    int passed = 0;
    logic [2*RW-1:0] pq[$];
    logic [SW-1:0] sq[$];
    logic [2*RW-1:0] pe;
    logic [SW-1:0] se;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (dn_if.valid && dn_if.ready) begin
                if (pq.size() == 0) chk("unexpected_piece", 64'(pq.size()), 64'd1);
                else begin
                    pe = pq.pop_front();
                    chk("down_lo", 64'(dn_if.lo), 64'(pe[2*RW-1:RW]));
                    chk("down_hi", 64'(dn_if.hi), 64'(pe[RW-1:0]));
                end
            end
            if (dn_if.sum_valid) begin
                if (sq.size() == 0) chk("unexpected_sum", 64'(sq.size()), 64'd1);
                else begin
                    se = sq.pop_front();
                    chk("down_sum", 64'(dn_if.sum), 64'(se));
                end
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [RW-1:0] lo, input logic [RW-1:0] hi);
        pq.push_back({lo, hi});
    endtask
    task automatic send(input logic [RW-1:0] lo, input logic [RW-1:0] hi);
        int n;
        n = 0;
        up_if.lo = lo;
        up_if.hi = hi;
        up_if.valid = 1'b1;
        @(negedge clk);
        while (!up_if.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!up_if.ready) chk("send_timeout", 64'(up_if.ready), 64'd1);
        @(posedge clk);
        #1 up_if.valid = 1'b0;
    endtask
    task automatic pulse_sum(input logic [SW-1:0] s);
        up_if.sum = s;
        up_if.sum_valid = 1'b1;
        cyc(1);
        up_if.sum_valid = 1'b0;
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        up_if.valid = 1'b0;
        up_if.conf_done = 1'b0;
        up_if.sum_valid = 1'b0;
        dn_if.ready = 1'b1;
        #1;
        chk("rst_down_valid", 64'(dn_if.valid), 64'd0);
        chk("rst_down_lo", 64'(dn_if.lo), 64'd0);
        chk("rst_down_hi", 64'(dn_if.hi), 64'd0);
        chk("rst_conf_done", 64'(dn_if.conf_done), 64'd0);
        chk("rst_sum_valid", 64'(dn_if.sum_valid), 64'd0);
        chk("rst_sum", 64'(dn_if.sum), 64'd0);
        chk("rst_up_ready", 64'(up_if.ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        up_if.valid = 1'b0;
        up_if.lo = '0;
        up_if.hi = '0;
        up_if.conf_done = 1'b0;
        up_if.sum_valid = 1'b0;
        up_if.sum = '0;
        dn_if.ready = 1'b1;
        // Test 1: store into empty stage, sum token only honoured in DONE, modulo sum
        do_reset();
        send(3, 5);
        chk("t1_no_fwd", 64'(dn_if.valid), 64'd0);
        pulse_sum(56'd7);
        chk("t1_sum_ignored", 64'(dn_if.sum_valid), 64'd0);
        up_if.conf_done = 1'b1;
        cyc(1);
        chk("t1_conf_done", 64'(dn_if.conf_done), 64'd1);
        chk("t1_up_ready", 64'(up_if.ready), 64'd0);
        sq.push_back(56'd3);
        pulse_sum(56'd0);
        cyc(1);
        sq.push_back(56'd2);
        pulse_sum({SW{1'b1}});
        cyc(2);
        chk("t1_sum_drained", 64'(sq.size()), 64'd0);
        // Test 2: disjoint and right-side clip
        do_reset();
        send(10, 14);
        push(16, 20);
        send(16, 20);
        push(15, 18);
        send(12, 18);
        cyc(3);
        chk("t2_drained", 64'(pq.size()), 64'd0);
        // Test 3: two-sided split
        do_reset();
        send(10, 14);
        push(5, 9);
        push(15, 20);
        send(5, 20);
        chk("t3_ready_split", 64'(up_if.ready), 64'd0);
        chk("t3_first_lo", 64'(dn_if.lo), 64'd5);
        cyc(1);
        chk("t3_second_valid", 64'(dn_if.valid), 64'd1);
        chk("t3_second_lo", 64'(dn_if.lo), 64'd15);
        chk("t3_second_hi", 64'(dn_if.hi), 64'd20);
        cyc(2);
        chk("t3_drained", 64'(pq.size()), 64'd0);
        // Test 4: covered and malformed dropped; touching ranges pass through
        do_reset();
        send(10, 14);
        send(11, 13);
        send(9, 7);
        cyc(2);
        chk("t4_no_fwd", 64'(dn_if.valid), 64'd0);
`ifdef RANGE_CLIP_CELL_DEBUG_EN
        chk("t4_drop_cnt", 64'(dbg), 64'd2);
`endif
        push(15, 15);
        send(15, 15);
        push(9, 9);
        send(9, 9);
        cyc(3);
        chk("t4_drained", 64'(pq.size()), 64'd0);
        // Test 5: backpressure holds the piece; conf_done waits for drain
        do_reset();
        send(10, 14);
        dn_if.ready = 1'b0;
        push(20, 25);
        send(20, 25);
        up_if.conf_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t5_hold_valid", 64'(dn_if.valid), 64'd1);
            chk("t5_hold_lo", 64'(dn_if.lo), 64'd20);
            chk("t5_hold_hi", 64'(dn_if.hi), 64'd25);
            chk("t5_up_ready", 64'(up_if.ready), 64'd0);
            chk("t5_conf_wait", 64'(dn_if.conf_done), 64'd0);
        end
        dn_if.ready = 1'b1;
        cyc(1);
        chk("t5_conf_after_drain", 64'(dn_if.conf_done), 64'd0);
        cyc(1);
        chk("t5_conf_set", 64'(dn_if.conf_done), 64'd1);
        chk("t5_drained", 64'(pq.size()), 64'd0);
        // Test 6: reset during SPLIT discards stored range and pending piece
        do_reset();
        send(10, 14);
        dn_if.ready = 1'b0;
        push(5, 9);
        send(5, 20);
        cyc(1);
        chk("t6_split_ready", 64'(up_if.ready), 64'd0);
        pq.delete();
        do_reset();
        send(5, 20);
        cyc(2);
        chk("t6_stored_fresh", 64'(dn_if.valid), 64'd0);
        send(8, 9);
        cyc(2);
        chk("t6_covered", 64'(dn_if.valid), 64'd0);
        chk("final_pieces", 64'(pq.size()), 64'd0);
        chk("final_sums", 64'(sq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
